countdown_timer_core: RTL

//  Parametrised countdown-timer controller. Takes pushbutton and BCD rotary-switch inputs and decrements a BCD M..M:SS count once per second.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_down_digit.sv | 23 ++
 rtl/countdown_timer_core.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer block.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_LOAD  = 2;

  localparam int BCD_MAX_UNITS = 9;
  localparam int BCD_MAX_TENS  = 5;

  // Rotary switch can present 10..15; treat those as 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'(BCD_MAX_UNITS)) ? 4'(BCD_MAX_UNITS) : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; borrow is raised when a decrement wraps it.
module bcd_down_digit #(
  parameter int MOD = 10
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       borrow
);

  assign borrow = dec && (q == 4'd0);

  // Load has priority over decrement; decrement from 0 wraps to MOD-1.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)     q <= 4'd0;
    else if (load) q <= ld_val;
    else if (dec)  q <= (q == 4'd0) ? 4'(MOD - 1) : q - 4'd1;
  end

endmodule

// File: rtl/countdown_timer_core.sv
// Countdown timer controller: button sync/edge detect, BCD M..M:SS count,
// start/pause/stop/alarm sequencing, buzzer and status LEDs.
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int MIN_DIGITS = 1,
  parameter int ALARM_SEC  = 30,
  parameter int BZ_HALF    = 1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [3:0]              PSW,
  input  logic [3:0]              RSW,
  output logic [3:0]              OUT_1S,
  output logic [3:0]              OUT_10S,
  output logic [4*MIN_DIGITS-1:0] OUT_M,
  output logic                    BZ,
  output logic [7:0]              LED
);

  localparam int NDIG = 2 + MIN_DIGITS;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int BW   = (BZ_HALF > 1) ? $clog2(BZ_HALF) : 1;

  state_t                  state;
  logic [PW-1:0]           presc, presc_nxt;
  logic [7:0]              alm_cnt;
  logic [BW-1:0]           bz_cnt;
  logic                    blink;
  logic [2:0]              s1, s2, s3, ev;
  logic                    ev_start, ev_stop, ev_load;
  logic                    tick, cnt_zero, cnt_dec, clr, min_load;
  logic [NDIG-1:0][3:0]    dig_q;
  logic                    unused_bits;

  // Sync regs reset to 1 so a button held through reset yields no event.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= PSW[2:0];
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ev       = s2 & ~s3;
  assign ev_stop  = ev[BTN_STOP];
  assign ev_start = ev[BTN_START] && !ev_stop;
  assign ev_load  = ev[BTN_LOAD] && !ev_start && !ev_stop;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign presc_nxt = tick ? '0 : presc + PW'(1);
  assign cnt_zero  = (dig_q == '0);
  assign cnt_dec   = (state == RUN) && !ev_stop && !ev_start && !cnt_zero && tick;
  assign clr       = ev_stop;
  assign min_load  = ev_load && (state == IDLE);

  // Digit 0 = seconds units, 1 = seconds tens, 2.. = minutes (low first).
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam int DMOD = (i == 1) ? BCD_MAX_TENS + 1 : BCD_MAX_UNITS + 1;
    logic       dec, ld, bor;
    logic [3:0] lv, q;

    if (i == 0) begin : g_d0
      assign dec = cnt_dec;
    end else begin : g_dn
      assign dec = g_dig[i-1].bor;
    end

    if (i < 2) begin : g_sec
      assign ld = clr;
      assign lv = 4'd0;
    end else if (i == 2) begin : g_m0
      assign ld = clr || min_load;
      assign lv = clr ? 4'd0 : clamp_bcd(RSW);
    end else begin : g_mn
      assign ld = clr || min_load;
      assign lv = clr ? 4'd0 : dig_q[i-1];
    end

    bcd_down_digit #(.MOD(DMOD)) u_digit (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .dec    (dec),
      .load   (ld),
      .ld_val (lv),
      .q      (q),
      .borrow (bor)
    );

    assign dig_q[i] = q;
  end

  assign OUT_1S  = dig_q[0];
  assign OUT_10S = dig_q[1];
  assign OUT_M   = dig_q[NDIG-1:2];

  assign unused_bits = PSW[3] ^ g_dig[NDIG-1].bor;

  // Main sequencer: state, prescaler, alarm timing, buzzer and tick blink.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      presc   <= '0;
      alm_cnt <= '0;
      bz_cnt  <= '0;
      BZ      <= 1'b0;
      blink   <= 1'b0;
    end else if (ev_stop) begin
      state   <= IDLE;
      presc   <= '0;
      alm_cnt <= '0;
      bz_cnt  <= '0;
      BZ      <= 1'b0;
      blink   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_start && !cnt_zero) begin
            state <= RUN;
            presc <= '0;
          end
        end
        RUN: begin
          if (cnt_zero) begin
            // Last tick already landed on 00:00; prescaler keeps its phase.
            state   <= ALARM;
            presc   <= presc_nxt;
            alm_cnt <= '0;
            bz_cnt  <= '0;
            BZ      <= 1'b1;
            blink   <= 1'b0;
          end else if (ev_start) begin
            state <= PAUSE;
            blink <= 1'b0;
          end else begin
            presc <= presc_nxt;
            if (tick) blink <= ~blink;
          end
        end
        PAUSE: begin
          if (ev_start) state <= RUN;
        end
        ALARM: begin
          if (tick && alm_cnt == 8'(ALARM_SEC - 1)) begin
            state   <= IDLE;
            presc   <= '0;
            alm_cnt <= '0;
            bz_cnt  <= '0;
            BZ      <= 1'b0;
          end else begin
            presc <= presc_nxt;
            if (tick) alm_cnt <= alm_cnt + 8'd1;
            if (bz_cnt == BW'(BZ_HALF - 1)) begin
              BZ     <= ~BZ;
              bz_cnt <= '0;
            end else begin
              bz_cnt <= bz_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status LEDs follow the registered state one cycle later.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) LED <= 8'h00;
    else       LED <= {(state == RUN) && blink, 4'b0000,
                       state == ALARM, state == PAUSE, state == RUN};
  end

endmodule
